// File: rtl/id_operand_stage.sv
// Decode/operand stage: registers the ex_* payload one cycle after accept, holds it under ex backpressure,
// and stalls one load-use hazard via a RUN/STALL FSM. Write-back bypass into the operand latches: ID_WB_BYPASS_EN.
module id_operand_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] instr,
   input  logic [DATA_W-1:0] pc,
   output logic              instr_ready,
   output logic [ADDR_W-1:0] rf_addr1,
   output logic [ADDR_W-1:0] rf_addr2,
   input  logic [DATA_W-1:0] rf_out1,
   input  logic [DATA_W-1:0] rf_out2,
   input  logic              wb_rw,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [DATA_W-1:0] ex_rs_val,
   output logic [DATA_W-1:0] ex_rt_val,
   output logic [DATA_W-1:0] ex_imm,
   output logic [ADDR_W-1:0] ex_rd,
   output logic [5:0]        ex_op,
   output logic [5:0]        ex_funct,
   output logic              ex_is_load,
   output logic [DATA_W-1:0] ex_pc,
   input  logic              flush
);

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   state_t state_q, state_d;

   logic              ex_valid_q,   ex_valid_d;
   logic [DATA_W-1:0] ex_rs_val_q,  ex_rs_val_d;
   logic [DATA_W-1:0] ex_rt_val_q,  ex_rt_val_d;
   logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
   logic [ADDR_W-1:0] ex_rd_q,      ex_rd_d;
   logic [5:0]        ex_op_q,      ex_op_d;
   logic [5:0]        ex_funct_q,   ex_funct_d;
   logic              ex_is_load_q, ex_is_load_d;
   logic [DATA_W-1:0] ex_pc_q,      ex_pc_d;

   logic [5:0]        op;
   logic [5:0]        funct;
   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rt;
   logic [ADDR_W-1:0] rd_fld;
   logic [ADDR_W-1:0] rd_sel;
   logic [DATA_W-1:0] imm_sext;
   logic [DATA_W-1:0] rs_val_sel;
   logic [DATA_W-1:0] rt_val_sel;
   logic              rt_is_src;
   logic              hazard;
   logic              ready;
   logic              accept;

   assign op       = instr[31:26];
   assign funct    = instr[5:0];
   assign rs       = ADDR_W'(instr[25:21]);
   assign rt       = ADDR_W'(instr[20:16]);
   assign rd_fld   = ADDR_W'(instr[15:11]);
   assign imm_sext = {{(DATA_W-16){instr[15]}}, instr[15:0]};

   assign rf_addr1 = rs;
   assign rf_addr2 = rt;

   always_comb begin
      case (op)
         OP_RTYPE:      rd_sel = rd_fld;
         OP_SW, OP_BEQ: rd_sel = '0;
         default:       rd_sel = rt;
      endcase
   end

   // Register $0 always reads as zero, even when the write-back bus targets it.
`ifdef ID_WB_BYPASS_EN
   always_comb begin
      rs_val_sel = rf_out1;
      rt_val_sel = rf_out2;
      if (wb_rw && (wb_addr == rs)) rs_val_sel = wb_data;
      if (wb_rw && (wb_addr == rt)) rt_val_sel = wb_data;
      if (rs == '0) rs_val_sel = '0;
      if (rt == '0) rt_val_sel = '0;
   end
`else
   logic unused_wb;
   assign unused_wb = ^{wb_rw, wb_addr, wb_data};

   always_comb begin
      rs_val_sel = rf_out1;
      rt_val_sel = rf_out2;
      if (rs == '0) rs_val_sel = '0;
      if (rt == '0) rt_val_sel = '0;
   end
`endif

   // Only loads sitting in EX can create a hazard; rt is read only by R-type, sw and beq.
   assign rt_is_src = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
   assign hazard    = ex_valid_q && ex_is_load_q && (ex_rd_q != '0) &&
                      ((ex_rd_q == rs) || (rt_is_src && (ex_rd_q == rt)));

   assign ready       = (state_q == RUN) && !hazard && !flush && (!ex_valid_q || ex_ready);
   assign accept      = instr_valid && ready;
   assign instr_ready = ready;

   always_comb begin
      state_d      = state_q;
      ex_valid_d   = ex_valid_q;
      ex_rs_val_d  = ex_rs_val_q;
      ex_rt_val_d  = ex_rt_val_q;
      ex_imm_d     = ex_imm_q;
      ex_rd_d      = ex_rd_q;
      ex_op_d      = ex_op_q;
      ex_funct_d   = ex_funct_q;
      ex_is_load_d = ex_is_load_q;
      ex_pc_d      = ex_pc_q;

      case (state_q)
         RUN:     if (instr_valid && hazard) state_d = STALL;
         STALL:   if (!ex_valid_q || ex_ready) state_d = RUN;
         default: state_d = RUN;
      endcase

      if (flush) begin
         state_d    = RUN;
         ex_valid_d = 1'b0;
      end else if (accept) begin
         ex_valid_d   = 1'b1;
         ex_rs_val_d  = rs_val_sel;
         ex_rt_val_d  = rt_val_sel;
         ex_imm_d     = imm_sext;
         ex_rd_d      = rd_sel;
         ex_op_d      = op;
         ex_funct_d   = funct;
         ex_is_load_d = (op == OP_LW);
         ex_pc_d      = pc;
      end else if (ex_valid_q && ex_ready) begin
         ex_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= RUN;
         ex_valid_q   <= 1'b0;
         ex_rs_val_q  <= '0;
         ex_rt_val_q  <= '0;
         ex_imm_q     <= '0;
         ex_rd_q      <= '0;
         ex_op_q      <= '0;
         ex_funct_q   <= '0;
         ex_is_load_q <= 1'b0;
         ex_pc_q      <= '0;
      end else begin
         state_q      <= state_d;
         ex_valid_q   <= ex_valid_d;
         ex_rs_val_q  <= ex_rs_val_d;
         ex_rt_val_q  <= ex_rt_val_d;
         ex_imm_q     <= ex_imm_d;
         ex_rd_q      <= ex_rd_d;
         ex_op_q      <= ex_op_d;
         ex_funct_q   <= ex_funct_d;
         ex_is_load_q <= ex_is_load_d;
         ex_pc_q      <= ex_pc_d;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ex_rs_val  = ex_rs_val_q;
   assign ex_rt_val  = ex_rt_val_q;
   assign ex_imm     = ex_imm_q;
   assign ex_rd      = ex_rd_q;
   assign ex_op      = ex_op_q;
   assign ex_funct   = ex_funct_q;
   assign ex_is_load = ex_is_load_q;
   assign ex_pc      = ex_pc_q;

endmodule
